// File: rtl/td4_core.sv
// TD4-class single-cycle core: PC, registers A/B, carry flag, I/O latch.
// Fetches {opcode, imm} combinationally from an external ROM addressed by the PC.
module td4_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W+3:0]   rom_data,
  input  logic [DATA_W-1:0]   in_port,
  output logic [DATA_W-1:0]   out_port,
  output logic                carry,
  output logic [DATA_W-1:0]   reg_a,
  output logic [DATA_W-1:0]   reg_b,
  output logic                halt
);

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;

  logic [ADDR_W-1:0] pc;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [DATA_W:0]   sum_a;
  logic [DATA_W:0]   sum_b;

  logic [ADDR_W-1:0] pc_nxt;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;
  logic [DATA_W-1:0] out_nxt;
  logic              carry_nxt;
  logic              halt_nxt;
  logic              jump;

  assign rom_addr = pc;
  assign opcode   = rom_data[DATA_W+3:DATA_W];
  assign imm      = rom_data[DATA_W-1:0];
  assign sum_a    = {1'b0, reg_a} + {1'b0, imm};
  assign sum_b    = {1'b0, reg_b} + {1'b0, imm};

  // Jump target: zero-extend a narrow immediate, otherwise keep its low bits
  generate
    if (ADDR_W > DATA_W) begin : g_tgt_ext
      assign jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign jmp_tgt = imm[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    pc_nxt    = pc + ADDR_W'(1);
    a_nxt     = reg_a;
    b_nxt     = reg_b;
    out_nxt   = out_port;
    carry_nxt = 1'b0;
    halt_nxt  = 1'b0;
    jump      = 1'b0;
    case (opcode)
      OP_ADD_A:  {carry_nxt, a_nxt} = sum_a;
      OP_ADD_B:  {carry_nxt, b_nxt} = sum_b;
      OP_MOV_A:  a_nxt = imm;
      OP_MOV_B:  b_nxt = imm;
      OP_MOV_AB: a_nxt = reg_b;
      OP_MOV_BA: b_nxt = reg_a;
      OP_IN_A:   a_nxt = in_port;
      OP_IN_B:   b_nxt = in_port;
      OP_OUT_B:  out_nxt = reg_b;
      OP_OUT_I:  out_nxt = imm;
      OP_JMP:    jump = 1'b1;
      OP_JNC:    jump = !carry;
      default:   ;
    endcase
    // A taken jump back onto itself can never leave: flag it
    if (jump) begin
      pc_nxt   = jmp_tgt;
      halt_nxt = (jmp_tgt == pc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
      halt     <= 1'b0;
    end else if (en) begin
      pc       <= pc_nxt;
      reg_a    <= a_nxt;
      reg_b    <= b_nxt;
      out_port <= out_nxt;
      carry    <= carry_nxt;
      halt     <= halt_nxt;
    end
  end

endmodule

// File: tb/tb_td4_core.sv
// Directed bench for td4_core: small ROM programs with hand-computed results.
module tb_td4_core;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W+3:0] rom_data;
  logic [DATA_W-1:0] in_port = '0;
  logic [DATA_W-1:0] out_port;
  logic              carry;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic              halt;

  logic [7:0] rom [16];
  int n_chk = 0;
  int n_err = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  td4_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_port(in_port), .out_port(out_port), .carry(carry),
    .reg_a(reg_a), .reg_b(reg_b), .halt(halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ALU / carry
    fill_nop();
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'h01;
    en = 1'b1;
    do_reset();
    check("rst_pc", 32'(rom_addr), 0);
    check("rst_a", 32'(reg_a), 0);
    check("rst_out", 32'(out_port), 0);
    check("rst_halt", 32'(halt), 0);
    step(1);
    check("mov_a3", 32'(reg_a), 3);
    step(1);
    check("add_a", 32'(reg_a), 1);
    check("add_carry", 32'(carry), 1);
    step(1);
    check("jnc_nt_pc", 32'(rom_addr), 3);
    check("jnc_carry", 32'(carry), 0);
    step(1);
    check("add1_a", 32'(reg_a), 2);
    check("add1_carry", 32'(carry), 0);

    // I/O
    fill_nop();
    rom[0] = 8'hBA; rom[1] = 8'h75; rom[2] = 8'h90; rom[3] = 8'h20; rom[4] = 8'h40;
    in_port = 4'd9;
    do_reset();
    step(1);
    check("out_imm", 32'(out_port), 32'hA);
    step(2);
    check("out_b", 32'(out_port), 5);
    step(2);
    check("in_a", 32'(reg_a), 9);
    check("mov_ba", 32'(reg_b), 9);
    check("out_hold", 32'(out_port), 5);
    check("io_pc", 32'(rom_addr), 5);

    // JNC taken, then fall-through after a carrying ADD
    fill_nop();
    rom[0] = 8'h30; rom[1] = 8'hE6; rom[6] = 8'h31; rom[7] = 8'h0F; rom[8] = 8'hE6;
    do_reset();
    step(2);
    check("jnc_taken", 32'(rom_addr), 6);
    step(2);
    check("add15_carry", 32'(carry), 1);
    check("add15_a", 32'(reg_a), 0);
    step(1);
    check("jnc_fall", 32'(rom_addr), 9);
    check("jnc_halt", 32'(halt), 0);

    // Self-loop
    fill_nop();
    rom[7] = 8'hF7;
    do_reset();
    step(7);
    check("loop_reach", 32'(rom_addr), 7);
    check("loop_nohalt", 32'(halt), 0);
    step(2);
    check("loop_pc", 32'(rom_addr), 7);
    check("loop_halt", 32'(halt), 1);
    rom[7] = 8'h80;
    step(1);
    check("unloop_pc", 32'(rom_addr), 8);
    check("unloop_halt", 32'(halt), 0);

    // Enable hold
    fill_nop();
    rom[0] = 8'h37; rom[1] = 8'h72; rom[2] = 8'hB3; rom[4] = 8'h0F;
    do_reset();
    step(4);
    check("en_pc0", 32'(rom_addr), 4);
    en = 1'b0;
    step(3);
    check("en_pc", 32'(rom_addr), 4);
    check("en_a", 32'(reg_a), 7);
    check("en_b", 32'(reg_b), 2);
    check("en_out", 32'(out_port), 3);
    check("en_carry", 32'(carry), 0);
    en = 1'b1;
    step(1);
    check("en_resume_a", 32'(reg_a), 6);
    check("en_resume_c", 32'(carry), 1);
    check("en_resume_pc", 32'(rom_addr), 5);

    // PC wrap
    fill_nop();
    do_reset();
    step(14);
    check("wrap14", 32'(rom_addr), 14);
    step(1);
    check("wrap15", 32'(rom_addr), 15);
    step(1);
    check("wrap0", 32'(rom_addr), 0);
    step(1);
    check("wrap1", 32'(rom_addr), 1);

    // Async reset between edges
    fill_nop();
    rom[0] = 8'hB5; rom[1] = 8'h3C; rom[2] = 8'h7D; rom[3] = 8'h0F;
    do_reset();
    step(9);
    check("pre_pc", 32'(rom_addr), 9);
    check("pre_out", 32'(out_port), 5);
    check("pre_a", 32'(reg_a), 32'hB);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", 32'(rom_addr), 0);
    check("arst_a", 32'(reg_a), 0);
    check("arst_b", 32'(reg_b), 0);
    check("arst_out", 32'(out_port), 0);
    check("arst_carry", 32'(carry), 0);
    check("arst_halt", 32'(halt), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    check("post_first", 32'(out_port), 5);
    check("post_pc", 32'(rom_addr), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/td4_core.md
# td4_core

Parametrised TD4-class processor core: program counter, registers A and B, carry flag, input/output ports and the full 12-instruction TD4 set, executing one instruction per enabled clock. Supersedes the earlier 4-opcode datapath with internal register state, jumps and I/O. Instructions come from an external combinational program ROM. It sits between the program ROM and the top-level user I/O pins.

## Interface
- DATA_W, 4: register, immediate and I/O port width (≥ 2)
- ADDR_W, 4: program counter and ROM address width (≥ 1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  execute enable; state holds when low
- rom_addr  out  ADDR_W  equals the PC register
- rom_data  in  4+DATA_W  instruction `{opcode[3:0], imm[DATA_W-1:0]}`; valid combinationally in the same cycle
- in_port  in  DATA_W  external input, sampled at the executing edge
- out_port  out  DATA_W  output latch
- carry  out  1  carry flag
- reg_a  out  DATA_W  register A (debug)
- reg_b  out  DATA_W  register B (debug)
- halt  out  1  self-loop detected

## Operation
- Reset (async): PC, A, B, carry, out_port and halt all go to 0.
- Each rising clk edge with en=1 executes the instruction at rom_data.
- Each such edge updates PC ← PC+1 mod 2^ADDR_W, unless a jump is taken.
- Opcodes (imm = Im, mod 2^DATA_W):
  - 0000 ADD A,Im: A ← A+Im
  - 0101 ADD B,Im: B ← B+Im
  - 0011 MOV A,Im: A ← Im
  - 0111 MOV B,Im: B ← Im
  - 0001 MOV A,B: A ← B
  - 0100 MOV B,A: B ← A
  - 0010 IN A: A ← in_port
  - 0110 IN B: B ← in_port
  - 1001 OUT B: out_port ← B
  - 1011 OUT Im: out_port ← Im
  - 1111 JMP Im: PC ← Im[ADDR_W-1:0]
  - 1110 JNC Im: PC ← Im[ADDR_W-1:0] if the carry flag is 0 at the edge, else PC+1
  - All other opcodes: NOP (PC+1 only)
- Jump target width: zero-extended if ADDR_W > DATA_W; low bits taken if ADDR_W < DATA_W.
- Carry flag is written on every executed instruction:
  - ADD: set to the adder carry-out, bit DATA_W of the (DATA_W+1)-bit sum.
  - All other instructions, including JNC, NOP and jumps: cleared to 0.
- JNC therefore tests the carry left by the preceding executed instruction.
- halt:
  - Set to 1 when a taken JMP/JNC has target == current PC.
  - Cleared by any other executed instruction or by reset.
  - The core keeps executing; halt is informational.
- en=0: no register changes, including carry and halt.

## Timing
- Single-cycle execution: one instruction per enabled edge; no pipeline, no stalls.
- rom_addr is driven directly from the PC register; the ROM must return rom_data within the same cycle.
- All outputs are registered and update only at the executing edge (or on reset).
- out_port changes the edge after the OUT instruction is presented and holds until the next OUT.
- in_port must be stable around the executing edge; no synchronisation is performed inside the core.
- rst asserted mid-cycle: outputs are zero immediately, without waiting for clk.
- rst deasserted: the first instruction executed is the one at address 0, on the first enabled edge.
- en toggling between edges has no effect until the next rising edge.

## Test plan
- ALU/carry (DATA_W=4):
  - Program: MOV A,3; ADD A,14; JNC 0; ADD A,1.
  - Required: after the ADD, A=1, carry=1; JNC not taken, PC=3, carry=0; then A=2, carry=0.
- I/O:
  - OUT Im 0xA → out_port=0xA after that edge.
  - MOV B,5; OUT B → out_port=5.
  - in_port=9; IN A; MOV B,A → A=9, B=9, out_port remains 5.
- JNC taken:
  - MOV A,0; JNC 6 → PC=6.
  - ADD A,15 with A=1 → carry=1; the next JNC 6 falls through to PC+1.
- Self-loop: instruction at address 7 is JMP 7 → PC stays 7 and halt=1; replacing the ROM word with NOP → halt=0, PC=8.
- Enable and wrap:
  - en=0 for 3 cycles at PC=4 → PC and registers unchanged.
  - An all-NOP ROM with ADDR_W=4 → PC sequence 14, 15, 0, 1.
- Async reset: at PC=9 with out_port=5, assert rst between clock edges → PC, A, B, out_port, carry and halt read 0 before the next clk edge.
